sdram_port_arbiter: RTL
=======================

// Module: sdram_port_arbiter
// PURPOSE
// Shares the single SDRAM controller burst interface between two FIFO-control client ports (P0, P1).
// Each port issues independent burst write and burst read requests with an address and length.
// One burst is granted at a time. Writes take priority over reads, and ports are served round-robin.
// Acks and data are steered back to the granted port only. Sits between the FIFO controllers and the SDRAM controller.
// PARAMETERS
// AW       24    SDRAM address width
// DW       16    data width
// LW       10    burst length width
// TIMEOUT  1023  max clk_ref cycles in REQ state waiting for ack before abort
// PORTS
// clk_ref          in   1   controller clock, all logic on rising edge
// rst_n            in   1   asynchronous active-low reset
// sdram_init_done  in   1   SDRAM ready; no new grants while low
// pN_wr_req        in   1   port N (N=0,1) burst-write request, level
// pN_wr_addr       in   AW  port N write start address
// pN_wr_len        in   LW  port N write burst length
// pN_din           in   DW  port N write data (its write-FIFO q)
// pN_wr_ack        out  1   port N write ack (= FIFO rdreq)
// pN_rd_req        in   1   port N burst-read request, level
// pN_rd_addr       in   AW  port N read start address
// pN_rd_len        in   LW  port N read burst length
// pN_rd_ack        out  1   port N read ack (= FIFO wrreq)
// pN_dout          out  DW  read data to port N (broadcast of sdram_dout)
// sdram_wr_req     out  1   write request to controller
// sdram_wr_ack     in   1   controller write ack, high for the whole data phase
// sdram_wr_addr    out  AW  latched write address
// sdram_wr_len     out  LW  latched write burst length
// sdram_din        out  DW  write data muxed from granted port
// sdram_rd_req     out  1   read request to controller
// sdram_rd_ack     in   1   controller read ack, high while read data valid
// sdram_rd_addr    out  AW  latched read address
// sdram_rd_len     out  LW  latched read burst length
// sdram_dout       in   DW  read data from controller
// grant_port       out  1   currently/last granted port
// busy             out  1   high in any state except IDLE
// timeout_err      out  1   one-cycle pulse on request abort
// BEHAVIOUR
// - Reset: all outputs 0, FSM=IDLE, round-robin pointer rr=0, latched addr/len=0.
// - FSM states: IDLE -> REQ -> XFER -> DONE -> IDLE. Abort path: REQ -> IDLE on timeout.
// - IDLE: if sdram_init_done=1 and any request is high, select one:
//   - Any pending write beats any read.
//   - Among same-type requests, port rr wins. The other port wins only if rr's request is low.
//   - Latch port, direction, addr and len, then go to REQ.
// - REQ: drive sdram_wr_req or sdram_rd_req high (exactly one) from the cycle after selection.
//   - Hold it until the matching ack is sampled high, then go to XFER and drop req in that same cycle.
//   - The client request dropping in REQ does not abort the burst.
//   - A timeout counter runs in REQ only. On reaching TIMEOUT: drop req, pulse timeout_err, go to IDLE, leave rr unchanged.
// - XFER: stay while the ack is high. On the first cycle the ack is sampled low, go to DONE.
// - DONE: one cycle. Set rr = ~granted port, then go to IDLE. Bursts are separated by at least one idle cycle.
// - Latched sdram_*_addr and sdram_*_len are held stable from REQ through DONE. They change only on a new selection.
// - Ack steering (combinational): pN_wr_ack = sdram_wr_ack & wr_grant & (grant_port==N); pN_rd_ack likewise.
//   - An ack arriving in IDLE, or of the non-granted direction, is routed to no port.
// - sdram_din = pN_din of grant_port (combinational mux). pN_dout = sdram_dout for both ports.
// - sdram_init_done falling mid-burst: the current burst completes normally; no new selection afterwards.
// - Simultaneous wr and rd on the same port: the write is served first, and the read is re-arbitrated next IDLE.
// - Asynchronous reset mid-burst: immediate return to reset values. Controller-side recovery is the controller's job.
// TESTING
// - After reset, hold init_done=0 with p0_wr_req=1 -> no sdram_wr_req. Set init_done=1 -> sdram_wr_req high 2 cycles later (IDLE select, then REQ).
// - p0_wr_req=1 addr=0x000100 len=256, ack high 256 cycles -> sdram_wr_addr=0x000100, sdram_wr_len=256, p0_wr_ack pulses 256, p1_wr_ack stays 0.
// - p0_wr_req and p1_wr_req held high continuously -> grants alternate P0,P1,P0,P1 over 4 bursts.
// - p1_rd_req and p0_wr_req both high, rr=1 -> P0 write granted first, then P1 read.
// - TIMEOUT=16, p0_rd_req=1, no ack -> sdram_rd_req drops after 16 cycles, one timeout_err pulse, FSM returns to IDLE.
// - init_done falls during XFER of a 64-word burst -> all 64 acks delivered, then no further sdram_*_req.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Shares one SDRAM controller burst interface between two FIFO-control client
// ports (P0, P1). One burst is granted at a time; any pending write beats any
// read, and same-type requests are served round-robin. Acks are steered back
// to the granted port and direction only.
//
// Ports:
//   clk_ref, rst_n            controller clock, async active-low reset
//   sdram_init_done           no new grants while low
//   pN_wr_req/addr/len/din    port N burst-write request and write data
//   pN_wr_ack                 port N write ack (FIFO rdreq)
//   pN_rd_req/addr/len        port N burst-read request
//   pN_rd_ack, pN_dout        port N read ack (FIFO wrreq) and read data
//   sdram_wr_*/sdram_rd_*     controller-side request, ack, latched addr/len
//   sdram_din, sdram_dout     controller write / read data
//   grant_port                currently or last granted port
//   busy                      high outside IDLE
//   timeout_err               one-cycle pulse after a request abort
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for init_done and a client request; selects a burst
// REQ   | sdram_*_req high, waiting for the ack; timeout runs here
// XFER  | data phase, stays while the ack is high
// DONE  | one cycle gap; advances the round-robin pointer

module sdram_port_arbiter #(
  parameter int AW      = 24,
  parameter int DW      = 16,
  parameter int LW      = 10,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk_ref,
  input  logic          rst_n,
  input  logic          sdram_init_done,
  input  logic          p0_wr_req,
  input  logic [AW-1:0] p0_wr_addr,
  input  logic [LW-1:0] p0_wr_len,
  input  logic [DW-1:0] p0_din,
  output logic          p0_wr_ack,
  input  logic          p0_rd_req,
  input  logic [AW-1:0] p0_rd_addr,
  input  logic [LW-1:0] p0_rd_len,
  output logic          p0_rd_ack,
  output logic [DW-1:0] p0_dout,
  input  logic          p1_wr_req,
  input  logic [AW-1:0] p1_wr_addr,
  input  logic [LW-1:0] p1_wr_len,
  input  logic [DW-1:0] p1_din,
  output logic          p1_wr_ack,
  input  logic          p1_rd_req,
  input  logic [AW-1:0] p1_rd_addr,
  input  logic [LW-1:0] p1_rd_len,
  output logic          p1_rd_ack,
  output logic [DW-1:0] p1_dout,
  output logic          sdram_wr_req,
  input  logic          sdram_wr_ack,
  output logic [AW-1:0] sdram_wr_addr,
  output logic [LW-1:0] sdram_wr_len,
  output logic [DW-1:0] sdram_din,
  output logic          sdram_rd_req,
  input  logic          sdram_rd_ack,
  output logic [AW-1:0] sdram_rd_addr,
  output logic [LW-1:0] sdram_rd_len,
  input  logic [DW-1:0] sdram_dout,
  output logic          grant_port,
  output logic          busy,
  output logic          timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DONE} state_t;

  // Down-counter loaded on selection; REQ lasts at most TIMEOUT cycles.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          gnt_wr_q;
  logic          rr_q;
  logic [TW-1:0] tmo_q;
  logic          load;
  logic          abort;
  logic          ack_sel;

  logic any_wr, any_rd, sel_valid, sel_wr, rr_has_req, sel_port;

  // Writes win over reads; within the chosen type the rr port wins unless
  // its own request of that type is low.
  assign any_wr     = p0_wr_req | p1_wr_req;
  assign any_rd     = p0_rd_req | p1_rd_req;
  assign sel_valid  = any_wr | any_rd;
  assign sel_wr     = any_wr;
  assign rr_has_req = sel_wr ? (rr_q ? p1_wr_req : p0_wr_req)
                             : (rr_q ? p1_rd_req : p0_rd_req);
  assign sel_port   = rr_has_req ? rr_q : ~rr_q;

  assign ack_sel = gnt_wr_q ? sdram_wr_ack : sdram_rd_ack;

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    load         = 1'b0;
    abort        = 1'b0;
    sdram_wr_req = 1'b0;
    sdram_rd_req = 1'b0;
    busy         = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (sdram_init_done && sel_valid) begin
          load    = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        sdram_wr_req = gnt_wr_q;
        sdram_rd_req = ~gnt_wr_q;
        // An ack on the terminal cycle still wins over the abort.
        if (ack_sel) begin
          state_d = S_XFER;
        end else if (tmo_q == '0) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_XFER: begin
        if (!ack_sel) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      grant_port    <= 1'b0;
      gnt_wr_q      <= 1'b0;
      rr_q          <= 1'b0;
      tmo_q         <= '0;
      timeout_err   <= 1'b0;
      sdram_wr_addr <= '0;
      sdram_wr_len  <= '0;
      sdram_rd_addr <= '0;
      sdram_rd_len  <= '0;
    end else begin
      timeout_err <= abort;
      if (load) begin
        grant_port <= sel_port;
        gnt_wr_q   <= sel_wr;
        tmo_q      <= TMO_LOAD;
        // Only the selected direction's address/length registers move, so
        // both stay stable from REQ through DONE.
        if (sel_wr) begin
          sdram_wr_addr <= sel_port ? p1_wr_addr : p0_wr_addr;
          sdram_wr_len  <= sel_port ? p1_wr_len  : p0_wr_len;
        end else begin
          sdram_rd_addr <= sel_port ? p1_rd_addr : p0_rd_addr;
          sdram_rd_len  <= sel_port ? p1_rd_len  : p0_rd_len;
        end
      end else if (state_q == S_REQ && tmo_q != '0) begin
        tmo_q <= tmo_q - 1'b1;
      end
      // Aborted requests never reach DONE, so rr is left untouched by them.
      if (state_q == S_DONE) begin
        rr_q <= ~grant_port;
      end
    end
  end

  logic wr_grant, rd_grant;

  // Acks are only routed while a burst is in progress, so a stray ack in IDLE
  // or on the other direction reaches no port.
  assign wr_grant  = busy & gnt_wr_q;
  assign rd_grant  = busy & ~gnt_wr_q;

  assign p0_wr_ack = sdram_wr_ack & wr_grant & ~grant_port;
  assign p1_wr_ack = sdram_wr_ack & wr_grant &  grant_port;
  assign p0_rd_ack = sdram_rd_ack & rd_grant & ~grant_port;
  assign p1_rd_ack = sdram_rd_ack & rd_grant &  grant_port;

  assign sdram_din = grant_port ? p1_din : p0_din;
  assign p0_dout   = sdram_dout;
  assign p1_dout   = sdram_dout;

endmodule
